// File: rtl/mul64_pkg.sv
// Shared definitions for the sequential 64x64 multiplier: widths, FSM states
// and the partial-product shift for each state.
package mul64_pkg;

  localparam int HALF_W = 32;
  localparam int FULL_W = 64;
  localparam int PROD_W = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Weight of the partial product computed in each multiply state.
  function automatic logic [6:0] pp_shift(state_t s);
    logic [6:0] sh;
    sh = 7'd0;
    case (s)
      P1, P2:  sh = 7'd32;
      P3:      sh = 7'd64;
      default: sh = 7'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mul64_seq_ctrl_ve32.sv
// ve32: purely combinational 32x32 -> 64 unsigned multiplier shared by the
// sequential 64-bit multiplier.
module ve32
  import mul64_pkg::*;
(
  input  logic [HALF_W-1:0] x,
  input  logic [HALF_W-1:0] y,
  output logic [FULL_W-1:0] p
);

  assign p = FULL_W'(x) * FULL_W'(y);

endmodule

// File: rtl/mul64_seq_ctrl.sv
// Sequential 64x64 -> 128 unsigned multiplier built on one shared 32x32 core.
// Optional macro MUL64_ZERO_SKIP_EN bypasses partial products of zero halves.
module mul64_seq_ctrl
  import mul64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       a,
  input  logic [63:0]       b,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      result,
  output logic              busy
);

  state_t              state_reg, state_next;
  logic [FULL_W-1:0]   a_reg, b_reg;
  logic [PROD_W-1:0]   acc_reg;
  logic [HALF_W-1:0]   mul_x, mul_y;
  logic [FULL_W-1:0]   pp;
  logic                accept;
  logic                a_hi_nz, b_hi_nz;
  logic                in_mult;

  assign in_ready  = (state_reg == IDLE);
  assign accept    = start & in_ready;
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign result    = out_valid ? acc_reg : '0;
  assign a_hi_nz   = |a_reg[FULL_W-1:HALF_W];
  assign b_hi_nz   = |b_reg[FULL_W-1:HALF_W];
  assign in_mult   = (state_reg == P0) || (state_reg == P1) ||
                     (state_reg == P2) || (state_reg == P3);

  // Operand halves for the shared multiplier, selected by the current state.
  always_comb begin
    mul_x = a_reg[HALF_W-1:0];
    mul_y = b_reg[HALF_W-1:0];
    case (state_reg)
      P1: mul_y = b_reg[FULL_W-1:HALF_W];
      P2: mul_x = a_reg[FULL_W-1:HALF_W];
      P3: begin
        mul_x = a_reg[FULL_W-1:HALF_W];
        mul_y = b_reg[FULL_W-1:HALF_W];
      end
      default: ;
    endcase
  end

  ve32 u_ve32 (
    .x (mul_x),
    .y (mul_y),
    .p (pp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = P0;
`ifdef MUL64_ZERO_SKIP_EN
      // P1 is only reached with b_hi != 0, P2 only with a_hi != 0.
      P0: begin
        if (b_hi_nz)      state_next = P1;
        else if (a_hi_nz) state_next = P2;
        else              state_next = DONE;
      end
      P1: state_next = a_hi_nz ? P2 : DONE;
      P2: state_next = b_hi_nz ? P3 : DONE;
`else
      P0: state_next = P1;
      P1: state_next = P2;
      P2: state_next = P3;
`endif
      P3:   state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc_reg <= '0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      acc_reg <= '0;
    end else if (in_mult) begin
      acc_reg <= acc_reg + ({{(PROD_W-FULL_W){1'b0}}, pp} << pp_shift(state_reg));
    end
  end

endmodule

// File: tb/tb_mul64_seq_ctrl.sv
// Self-checking bench for mul64_seq_ctrl: behavioural model plus directed and
// randomized operations; honours MUL64_ZERO_SKIP_EN for latency expectations.
module tb_mul64_seq_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int n_ops  = 0;

  mul64_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] full_prod(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] wx, wy;
    wx = {64'd0, x};
    wy = {64'd0, y};
    return wx * wy;
  endfunction

  // Edges from the accepting edge (counted as 1) to the edge that raises out_valid.
  function automatic int lat_of(input logic [63:0] x, input logic [63:0] y);
`ifdef MUL64_ZERO_SKIP_EN
    int nz_a, nz_b;
    nz_a = (x[63:32] != 32'd0) ? 1 : 0;
    nz_b = (y[63:32] != 32'd0) ? 1 : 0;
    return 2 + nz_a + nz_b + nz_a * nz_b;
`else
    return 5;
`endif
  endfunction

  // Model: 0 = idle, 1 = computing, 2 = result held.
  int           m_mode = 0;
  int           m_left = 0;
  logic [127:0] m_prod = '0;
  int           deliveries = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_left <= 0;
      m_prod <= '0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode <= 1;
          m_left <= lat_of(a, b) - 1;
          m_prod <= full_prod(a, b);
        end
        1: begin
          if (m_left == 1) m_mode <= 2;
          m_left <= m_left - 1;
        end
        default: if (out_ready) begin
          m_mode     <= 0;
          deliveries <= deliveries + 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [127:0] exp_res;
      exp_res = (m_mode == 2) ? m_prod : 128'd0;
      checks++;
      if (in_ready !== (m_mode == 0) || busy !== (m_mode != 0) ||
          out_valid !== (m_mode == 2) || result !== exp_res) begin
        errors++;
        $display("FAIL model t=%0t in_ready=%b busy=%b out_valid=%b result=%h required mode=%0d result=%h",
                 $time, in_ready, busy, out_valid, result, m_mode, exp_res);
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for out_valid after %0d edges", n);
    end
  endtask

  task automatic do_op(input logic [63:0] oa, input logic [63:0] ob, input logic [127:0] exp,
                       input int exp_lat, input int hold);
    int n;
    logic [127:0] held;
    @(negedge clk);
    a = oa; b = ob; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    wait_valid(n);
    check("result", result, exp);
    check("latency", 128'(n), 128'(exp_lat));
    held = result;
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      @(negedge clk);
      check("hold_result", result, held);
      check("hold_valid", 128'(out_valid), 128'd1);
      check("hold_in_ready", 128'(in_ready), 128'd0);
    end
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released_valid", 128'(out_valid), 128'd0);
    n_ops++;
    $display("op a=%h b=%h result=%h latency=%0d hold=%0d", oa, ob, held, n, hold);
  endtask

  initial begin
    int n;
    logic [63:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    #1;
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_result", result, 128'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    do_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
          128'hFFFFFFFFFFFFFFFE0000000000000001, 5, 0);
    do_op(64'h0000000100000000, 64'h0000000100000000,
          128'h00000000000000010000000000000000, 5, 1);
`ifdef MUL64_ZERO_SKIP_EN
    do_op(64'd5, 64'd7, 128'd35, 2, 0);
    do_op(64'd0, 64'd0, 128'd0, 2, 0);
`else
    do_op(64'd5, 64'd7, 128'd35, 5, 0);
    do_op(64'd0, 64'd0, 128'd0, 5, 0);
`endif
    do_op(64'hFFFFFFFFFFFFFFFF, 64'd0, 128'd0, lat_of(64'hFFFFFFFFFFFFFFFF, 64'd0), 0);
    do_op(64'h0000000200000003, 64'h0000000400000005,
          128'h00000000000000080000001600000000 + 128'd15, 5, 3);

    // Reset while in P2: accept edge -> P0, then two more edges reach P2.
    @(negedge clk);
    a = 64'h1234567812345678; b = 64'h8765432187654321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_result", result, 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    do_op(64'd3, 64'd4, 128'd12, lat_of(64'd3, 64'd4), 0);

    // Back-to-back: second start held high across the handshake edge.
    @(negedge clk);
    a = 64'd6; b = 64'd7; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);
    check("b2b_first_result", result, 128'd42);
    a = 64'h00000000FFFFFFFF; b = 64'h00000000FFFFFFFF; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle_after_handshake", 128'(in_ready), 128'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_second_accepted", 128'(busy), 128'd1);
    wait_valid(n);
    check("b2b_second_result", result, 128'h0000000000000000FFFFFFFE00000001);
    check("b2b_second_latency", 128'(n), 128'(lat_of(64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF)));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_ops += 2;
    $display("op back-to-back results 42 and %h latency=%0d", 128'h0000000000000000FFFFFFFE00000001, n);

    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        1: ra[63:32] = '0;
        2: rb[63:32] = '0;
        3: begin ra[63:32] = '0; rb[63:32] = '0; end
        default: ;
      endcase
      do_op(ra, rb, full_prod(ra, rb), lat_of(ra, rb), $urandom_range(0, 3));
    end

    @(negedge clk);
    check("deliveries", 128'(deliveries), 128'(n_ops));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul64_seq_ctrl.md
MUL64_SEQ_CTRL -- requirements
Module: mul64_seq_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; the polarity and synchronicity of this reset are fixed.
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operand-valid request.
- a  input  64  unsigned multiplicand.
- b  input  64  unsigned multiplier.
- in_ready  output  1  block can accept an operation.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  128  unsigned product a*b.
- busy  output  1  an operation is in flight (state is not IDLE).

Function
REQ-003 The block SHALL compute the 128-bit product with a single shared combinational 32x32->64 multiplier, time-multiplexed over up to four partial-product cycles.
REQ-004 The FSM states SHALL be IDLE, P0, P1, P2, P3, DONE.
- P0 computes a_lo*b_lo, shift 0.
- P1 computes a_lo*b_hi, shift 32.
- P2 computes a_hi*b_lo, shift 32.
- P3 computes a_hi*b_hi, shift 64.
REQ-005 An operation SHALL be accepted when start and in_ready are both high at a rising edge; in_ready = (state==IDLE).
REQ-006 On acceptance, the block SHALL latch a and b into internal registers, clear the 128-bit accumulator, and go to P0; input changes after acceptance SHALL have no effect.
REQ-007 In each Pk state, the block SHALL add the zero-extended 64-bit partial product, shifted as listed in REQ-004, to the accumulator at the end of the cycle.
REQ-008 The accumulator SHALL be 128 bits wide, and no intermediate sum SHALL overflow it.
REQ-009 Without zero-skip, the state sequence SHALL be P0->P1->P2->P3->DONE, and out_valid SHALL assert exactly 5 rising edges after the accepting edge.
REQ-010 In DONE, out_valid SHALL be 1 and result SHALL equal the accumulator; result SHALL be held stable while out_ready is 0.
REQ-011 When out_valid and out_ready are both high, the block SHALL go DONE->IDLE; a new start SHALL be accepted no earlier than the following edge.
REQ-012 start SHALL be ignored while busy or in DONE; no operation is queued.
REQ-013 Outside DONE, result SHALL read 0.
REQ-014 Operands of all ones and all zeros SHALL produce exact products with no wrap.

Reset
REQ-015 Assertion of rst SHALL immediately force state=IDLE, the accumulator and operand registers to 0, out_valid=0, busy=0, result=0 and in_ready=1.
REQ-016 Reset asserted mid-operation SHALL abort the operation without producing any output; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-017 The block SHALL support the macro MUL64_ZERO_SKIP_EN.
REQ-018 With MUL64_ZERO_SKIP_EN defined, zero operand halves SHALL be skipped:
- If the latched a_hi==0, P2 and P3 SHALL be skipped.
- If the latched b_hi==0, P1 and P3 SHALL be skipped.
- Skipped states SHALL be bypassed in the same cycle; latency SHALL be 2 to 5 edges.
- A skip SHALL never change the result value.
REQ-019 Without MUL64_ZERO_SKIP_EN, latency SHALL be fixed at 5 edges for every operand.

Structure
REQ-020 Package mul64_pkg SHALL hold the FSM state enumeration and the constants HALF_W=32, FULL_W=64 and PROD_W=128.
REQ-021 The 32x32 multiplier SHALL be one instance of the existing ve32 sub-module, with its operand muxes driven by the FSM state.
REQ-022 The block SHALL contain no other sub-module.

Verification
REQ-023 The bench SHALL cover at least the following directed scenarios:
- Max operands: a=b=0xFFFFFFFFFFFFFFFF -> result=0xFFFFFFFFFFFFFFFE0000000000000001; out_valid 5 edges after accept (no macro).
- Cross term: a=b=0x0000000100000000 -> result=0x00000000000000010000000000000000.
- Backpressure: out_ready held 0 for 3 cycles in DONE -> result and out_valid stable, in_ready=0, start pulses ignored; the product is delivered once when out_ready=1.
- Reset mid-operation: rst pulsed while in P2 -> out_valid=0, busy=0, result=0 immediately; a following operation a=3, b=4 -> result=12.
- Zero-skip: a=5, b=7 -> result=35; out_valid 2 edges after accept with MUL64_ZERO_SKIP_EN defined, 5 edges without.
- Back-to-back: two operations, the second start held high during DONE -> the second is accepted on the edge after the handshake, and both results are correct.
